// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer:
// reconfig register map, FSM states, counter word layout and default profiles.
package pll_cfg_pkg;

  localparam logic [5:0]  ADDR_MODE    = 6'h00;
  localparam logic [5:0]  ADDR_START   = 6'h02;
  localparam logic [5:0]  ADDR_N       = 6'h03;
  localparam logic [5:0]  ADDR_M       = 6'h04;
  localparam logic [5:0]  ADDR_C       = 6'h05;

  localparam logic [31:0] MODE_WAITREQ = 32'd0;
  localparam logic [31:0] START_DATA   = 32'd0;
  localparam logic [4:0]  C0_SELECT    = 5'd0;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_MODE   = 4'd1,
    ST_WR_N      = 4'd2,
    ST_WR_M      = 4'd3,
    ST_WR_C0     = 4'd4,
    ST_WR_START  = 4'd5,
    ST_SETTLE    = 4'd6,
    ST_WAIT_LOCK = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERR       = 4'd9
  } pll_state_e;

  typedef struct packed {
    logic [13:0] rsvd;
    logic        odd;
    logic        bypass;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } pll_word_t;

  typedef struct packed {
    pll_word_t n;
    pll_word_t m;
    pll_word_t c0;
  } pll_profile_t;

  // 50 MHz refclk, N bypassed, M=6 -> 300 MHz VCO; C0 = 3/6/12/4 gives 100/50/25/75 MHz.
  localparam pll_profile_t PROFILE_TABLE [4] = '{
    '{n: 32'h0001_0000, m: 32'h0000_0303, c0: 32'h0002_0201},
    '{n: 32'h0001_0000, m: 32'h0000_0303, c0: 32'h0000_0303},
    '{n: 32'h0001_0000, m: 32'h0000_0303, c0: 32'h0000_0606},
    '{n: 32'h0001_0000, m: 32'h0000_0303, c0: 32'h0000_0202}
  };

  function automatic logic is_write_state(pll_state_e s);
    return s inside {ST_WR_MODE, ST_WR_N, ST_WR_M, ST_WR_C0, ST_WR_START};
  endfunction

  function automatic logic [15:0] sat_inc16(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pll_cfg_profile_rom.sv
// Combinational lookup of the N, M and C0 counter words for a profile select.
module pll_cfg_profile_rom
  import pll_cfg_pkg::*;
(
  input  logic [1:0]  sel_i,
  output logic [31:0] n_word_o,
  output logic [31:0] m_word_o,
  output logic [31:0] c0_word_o
);

  pll_profile_t entry;

  always_comb begin
    entry     = PROFILE_TABLE[sel_i];
    n_word_o  = entry.n;
    m_word_o  = entry.m;
    c0_word_o = entry.c0;
  end

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: writes a selected divider profile through the
// Avalon-MM reconfig port, then waits for the PLL to relock or time out.
module pll_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  // The timeout counter saturates at 16 bits, so longer timeouts are clamped to its reach.
  localparam int unsigned TimeoutEff = (LOCK_TIMEOUT > 32'd65536) ? 32'd65536 : LOCK_TIMEOUT;

  pll_state_e  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [15:0] timeout_cnt_q, timeout_cnt_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        write_q, write_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        lock_meta_q, lock_sync_q;
  logic [31:0] n_word, m_word, c0_word;
  logic        settle_last, timeout_last;

  pll_cfg_profile_rom u_rom (
    .sel_i     (sel_q),
    .n_word_o  (n_word),
    .m_word_o  (m_word),
    .c0_word_o (c0_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign settle_last  = (32'(settle_cnt_q) + 32'd1) >= SETTLE_CYCLES;
  assign timeout_last = (32'(timeout_cnt_q) + 32'd1) >= TimeoutEff;

  // Each write state holds until the controller drops waitrequest; lock wins over timeout.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    settle_cnt_d  = settle_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    err_d         = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_req) begin
          sel_d   = cfg_sel;
          err_d   = 1'b0;
          state_d = ST_WR_MODE;
        end
      end
      ST_WR_MODE:  if (!mgmt_waitrequest) state_d = ST_WR_N;
      ST_WR_N:     if (!mgmt_waitrequest) state_d = ST_WR_M;
      ST_WR_M:     if (!mgmt_waitrequest) state_d = ST_WR_C0;
      ST_WR_C0:    if (!mgmt_waitrequest) state_d = ST_WR_START;
      ST_WR_START: begin
        if (!mgmt_waitrequest) begin
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_last) begin
          timeout_cnt_d = '0;
          state_d       = ST_WAIT_LOCK;
        end else begin
          settle_cnt_d = sat_inc16(settle_cnt_q);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync_q) begin
          state_d = ST_DONE;
        end else if (timeout_last) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          timeout_cnt_d = sat_inc16(timeout_cnt_q);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the bus sees glitch-free, stable values.
  always_comb begin
    write_d = is_write_state(state_d);
    addr_d  = '0;
    data_d  = '0;
    case (state_d)
      ST_WR_MODE: begin
        addr_d = ADDR_MODE;
        data_d = MODE_WAITREQ;
      end
      ST_WR_N: begin
        addr_d = ADDR_N;
        data_d = n_word;
      end
      ST_WR_M: begin
        addr_d = ADDR_M;
        data_d = m_word;
      end
      ST_WR_C0: begin
        addr_d        = ADDR_C;
        data_d        = c0_word;
        data_d[22:18] = C0_SELECT;
      end
      ST_WR_START: begin
        addr_d = ADDR_START;
        data_d = START_DATA;
      end
      default: begin
        addr_d = '0;
        data_d = '0;
      end
    endcase
    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      settle_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      settle_cnt_q  <= settle_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mgmt_write     = write_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Self-checking bench for pll_cfg_seq: table vectors, hand sequences for reset and
// ignored requests, and randomized runs against a transaction-level model.
module tb_pll_cfg_seq;

  localparam int Settle = 16;
  localparam int Tmo    = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_req = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic        busy, done, err;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;

  pll_cfg_seq #(.LOCK_TIMEOUT(Tmo), .SETTLE_CYCLES(Settle)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_req          (cfg_req),
    .cfg_sel          (cfg_sel),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    int          stall;
    int          lockAt;
    logic [31:0] expC0;
    bit          expDone;
    int          expLat;
  } vec_t;

  vec_t        vecs [7];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [37:0] obsQ [$];
  int          firstWrCyc, lastWrCyc, doneCyc, errCyc, doneCnt, m4Cycles, outLat, stallLeft;
  bit          randStall = 1'b0;
  bit          prevStall = 1'b0;
  logic [5:0]  prevAddr = '0;
  logic [31:0] prevData = '0;
  logic        errPrev = 1'b0;
  logic        busyAtOutcome = 1'b0;
  int          profileMhz [4] = '{100, 50, 25, 75};

  // Counter word for an integer divide ratio: bypass when 1, else high/low halves.
  function automatic logic [31:0] divWord(int c);
    if (c == 1) return 32'h0001_0000;
    return {14'd0, 1'(c % 2), 1'b0, 8'((c + 1) / 2), 8'(c / 2)};
  endfunction

  function automatic int lockSeen(int lockAt);
    int t;
    t = Settle + 1;
    if (lockAt == -1) return 1 << 20;
    if (lockAt >= 0 && lockAt + 2 > t) t = lockAt + 2;
    return t;
  endfunction

  function automatic bit modelDone(int lockAt);
    return lockSeen(lockAt) <= Settle + Tmo;
  endfunction

  function automatic int modelLat(int lockAt);
    return modelDone(lockAt) ? lockSeen(lockAt) + 1 : Settle + Tmo + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    if (prevStall)
      checkOutput("wr_hold", {mgmt_write, mgmt_address, mgmt_writedata}, {1'b1, prevAddr, prevData});
    prevStall = mgmt_write && mgmt_waitrequest;
    prevAddr  = mgmt_address;
    prevData  = mgmt_writedata;
    if (mgmt_write && mgmt_address == 6'h04) m4Cycles++;
    if (mgmt_write && !mgmt_waitrequest) begin
      if (obsQ.size() == 0) firstWrCyc = cyc;
      obsQ.push_back({mgmt_address, mgmt_writedata});
      lastWrCyc = cyc;
    end
    if (done) begin
      doneCnt++;
      if (doneCyc < 0) begin
        doneCyc = cyc;
        busyAtOutcome = busy;
      end
    end
    if (err && !errPrev) begin
      errCyc = cyc;
      busyAtOutcome = busy;
    end
    errPrev = err;
  endtask

  // Inputs change just after the rising edge; outputs are observed on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (randStall) begin
      mgmt_waitrequest = ($urandom_range(0, 3) == 0);
    end else if (stallLeft > 0 && mgmt_write && mgmt_address == 6'h04) begin
      mgmt_waitrequest = 1'b1;
      stallLeft--;
    end else begin
      mgmt_waitrequest = 1'b0;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input int stall, input int lockAt, input bit pulseWrN);
    int  guard;
    bit  pulsed;
    obsQ.delete();
    doneCyc = -1; errCyc = -1; doneCnt = 0; m4Cycles = 0; firstWrCyc = 0; lastWrCyc = 0;
    stallLeft = stall;
    pulsed = 1'b0;
    pll_locked = (lockAt == -2);
    if (lockAt == -2) repeat (3) tick();
    cfg_sel = sel;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    cfg_sel = ~sel;
    checkOutput("accept_busy", busy, 1);
    checkOutput("accept_err_clear", err, 0);
    guard = 0;
    while (obsQ.size() < 5 && guard < 200) begin
      if (pulseWrN && !pulsed && mgmt_write && mgmt_address == 6'h03) begin
        cfg_req = 1'b1;
        cfg_sel = 2'd3;
        pulsed  = 1'b1;
      end
      tick();
      cfg_req = 1'b0;
      guard++;
    end
    checkOutput("writes_before_bound", guard < 200, 1);
    if (lockAt >= 0) begin
      for (int i = 0; i < lockAt; i++) tick();
      pll_locked = 1'b1;
    end
    guard = 0;
    while (doneCyc < 0 && errCyc < 0 && guard < 300) begin
      tick();
      guard++;
    end
    checkOutput("outcome_before_bound", guard < 300, 1);
    repeat (3) tick();
    outLat = (doneCyc >= 0) ? doneCyc - lastWrCyc : (errCyc >= 0 ? errCyc - lastWrCyc : -1);
    pll_locked = 1'b0;
    repeat (3) tick();
  endtask

  task automatic checkWrites(input logic [31:0] n, input logic [31:0] m, input logic [31:0] c0);
    logic [5:0]  ea [5];
    logic [31:0] ed [5];
    ea = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h02};
    ed = '{32'd0, n, m, c0, 32'd0};
    checkOutput("write_count", obsQ.size(), 5);
    for (int i = 0; i < 5 && i < obsQ.size(); i++) begin
      checkOutput($sformatf("wr%0d_addr", i), obsQ[i][37:32], ea[i]);
      checkOutput($sformatf("wr%0d_data", i), obsQ[i][31:0], ed[i]);
    end
  endtask

  initial begin
    int          guard;
    logic [1:0]  rSel;
    int          rLock;

    vecs[0] = '{2'd0, 0, 0,   32'h0002_0201, 1'b1, 18};
    vecs[1] = '{2'd1, 3, 20,  32'h0000_0303, 1'b1, 23};
    vecs[2] = '{2'd2, 1, 114, 32'h0000_0606, 1'b1, 117};
    vecs[3] = '{2'd3, 0, -2,  32'h0000_0202, 1'b1, 18};
    vecs[4] = '{2'd0, 2, 15,  32'h0002_0201, 1'b1, 18};
    vecs[5] = '{2'd3, 0, 115, 32'h0000_0202, 1'b0, 117};
    vecs[6] = '{2'd1, 0, -1,  32'h0000_0303, 1'b0, 117};

    #2 rst_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_outputs", {busy, done, err, mgmt_write, mgmt_address, mgmt_writedata}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("idle_after_reset", {busy, mgmt_write}, 64'd0);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].sel, vecs[v].stall, vecs[v].lockAt, 1'b0);
      checkWrites(32'h0001_0000, 32'h0000_0303, vecs[v].expC0);
      checkOutput("write_span", lastWrCyc - firstWrCyc, 4 + vecs[v].stall);
      checkOutput("wr_m_cycles", m4Cycles, vecs[v].stall + 1);
      checkOutput("outcome_is_done", doneCyc >= 0, vecs[v].expDone);
      checkOutput("outcome_latency", outLat, vecs[v].expLat);
      checkOutput("done_pulses", doneCnt, vecs[v].expDone ? 1 : 0);
      checkOutput("busy_at_outcome", busyAtOutcome, 0);
      if (!vecs[v].expDone) checkOutput("err_sticky", err, 1);
    end

    $display("[TB] ignored request during WR_N, then reprogram after an error");
    checkOutput("err_before_req", err, 1);
    applyStimulus(2'd0, 0, 0, 1'b1);
    checkWrites(32'h0001_0000, 32'h0000_0303, 32'h0002_0201);
    checkOutput("ignored_req_done", doneCnt, 1);
    checkOutput("err_cleared", err, 0);
    applyStimulus(2'd2, 0, 0, 1'b0);
    checkWrites(32'h0001_0000, 32'h0000_0303, 32'h0000_0606);
    checkOutput("sel2_done", doneCnt, 1);

    $display("[TB] randomized runs against the reference model");
    randStall = 1'b1;
    for (int r = 0; r < 8; r++) begin
      rSel  = 2'($urandom_range(0, 3));
      rLock = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 125));
      applyStimulus(rSel, 0, rLock, 1'b0);
      checkWrites(divWord(1), divWord(6), divWord(300 / profileMhz[rSel]));
      checkOutput("rnd_outcome_is_done", doneCyc >= 0, modelDone(rLock));
      checkOutput("rnd_latency", outLat, modelLat(rLock));
      checkOutput("rnd_done_pulses", doneCnt, modelDone(rLock) ? 1 : 0);
    end
    randStall = 1'b0;
    mgmt_waitrequest = 1'b0;
    repeat (2) tick();

    $display("[TB] reset asserted during WR_C0");
    obsQ.delete();
    cfg_sel = 2'd1;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    guard = 0;
    while (!(mgmt_write && mgmt_address == 6'h05) && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("reached_wr_c0", {mgmt_write, mgmt_address}, {1'b1, 6'h05});
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {busy, done, err, mgmt_write, mgmt_address, mgmt_writedata}, 64'd0);
    prevStall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    obsQ.delete();
    repeat (30) tick();
    checkOutput("no_write_after_reset", obsQ.size(), 0);
    checkOutput("idle_after_release", {busy, done, err}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_cfg_seq.md
PLL_CFG_SEQ -- requirements
Module: pll_cfg_seq

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 65535; the maximum number of cycles to wait for lock.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16; the number of cycles to ignore pll_locked after start.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, which is also the management clock.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port cfg_req, input, 1 bit; a one-cycle reconfiguration request.
REQ-006 SHALL have port cfg_sel, input, 2 bits; selects the profile, sampled when cfg_req is accepted.
REQ-007 SHALL have port busy, output, 1 bit; high from request acceptance until DONE or ERR.
REQ-008 SHALL have port done, output, 1 bit; a one-cycle pulse on successful lock.
REQ-009 SHALL have port err, output, 1 bit; a sticky lock-timeout flag, cleared by the next accepted cfg_req.
REQ-010 SHALL have port mgmt_address, output, 6 bits; the Avalon-MM address to the PLL reconfig controller.
REQ-011 SHALL have port mgmt_write, output, 1 bit; the Avalon-MM write strobe.
REQ-012 SHALL have port mgmt_writedata, output, 32 bits; the Avalon-MM write data.
REQ-013 SHALL have port mgmt_waitrequest, input, 1 bit; the Avalon-MM stall.
REQ-014 SHALL have port pll_locked, input, 1 bit; PLL lock, asynchronous and double-flopped internally.

Function
REQ-015 SHALL use FSM states IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_START, SETTLE, WAIT_LOCK, DONE, ERR.
REQ-016 SHALL accept cfg_req only in IDLE; on acceptance it SHALL latch cfg_sel, set busy and clear err in the next cycle, and go to WR_MODE.
REQ-017 SHALL ignore cfg_req in all states other than IDLE; requests are not queued.
REQ-018 SHALL perform each WR_* state as one Avalon write: mgmt_write=1 with address and data held stable while mgmt_waitrequest=1; the write completes on the first cycle with mgmt_waitrequest=0, and the FSM advances in the next cycle.
REQ-019 SHALL issue these writes: WR_MODE addr 0x00 data 0 (waitrequest mode); WR_N addr 0x03 data N word; WR_M addr 0x04 data M word; WR_C0 addr 0x05 data C0 word with counter select [22:18]=0; WR_START addr 0x02 data 0.
REQ-020 SHALL take the N, M and C0 words from a 4-entry profile table indexed by the latched cfg_sel; each word is {bypass[16], odd[17], hi[15:8], lo[7:0]}.
REQ-021 SHALL hold SETTLE for SETTLE_CYCLES cycles, then enter WAIT_LOCK with the timeout counter at 0.
REQ-022 SHALL, in WAIT_LOCK, go to DONE when synced pll_locked=1; SHALL go to ERR when the counter reaches LOCK_TIMEOUT-1 with lock still low.
REQ-023 SHALL resolve lock and timeout arriving in the same cycle as a lock, i.e. go to DONE.
REQ-024 SHALL, in DONE, pulse done for one cycle, drop busy, and return to IDLE.
REQ-025 SHALL, in ERR, set err, drop busy, and return to IDLE.
REQ-026 SHALL hold mgmt_write=0 outside WR_* states.
REQ-027 SHALL never issue more than one mgmt_write per state.
REQ-028 SHALL size the timeout counter at 16 bits, saturating, never wrapping.

Reset
REQ-029 SHALL, on rst_n low, force state IDLE, busy=0, done=0, err=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, counters 0, and the sync flops 0.
REQ-030 SHALL abandon an in-flight write when reset is asserted mid-sequence; on release the block is idle and requires a new cfg_req.

Structure
REQ-031 SHALL place in shared package pll_cfg_pkg: the register address constants, the state enum, the profile word typedef, and the default 4-entry profile table (100/50/25/75 MHz from 50 MHz refclk).
REQ-032 SHALL use one sub-module, pll_cfg_profile_rom, mapping cfg_sel to the {N, M, C0} words combinationally.

Verification
REQ-033 SHALL verify: cfg_req with cfg_sel=0 and waitrequest=0 -> writes at addresses 0,3,4,5,2 on five consecutive write cycles; N=0x10000, M=0x0303, C0=0x20201; done 1 cycle after lock.
REQ-034 SHALL verify: waitrequest held high 3 cycles on the WR_M write -> address 0x04 and its data stable for 4 cycles; exactly one write accepted.
REQ-035 SHALL verify: pll_locked never rises, LOCK_TIMEOUT=100 -> err=1 and busy=0 exactly 100 cycles after SETTLE ends; no done.
REQ-036 SHALL verify: cfg_req pulsed during WR_N -> ignored; after done, a new cfg_req with cfg_sel=2 -> C0 word from entry 2, err cleared.
REQ-037 SHALL verify: rst_n low during WR_C0 -> all outputs 0 asynchronously; after release, no write without a new cfg_req.
REQ-038 SHALL verify: pll_locked high throughout SETTLE -> no early done; done occurs only after SETTLE_CYCLES.
